regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (writeEn/writeAddr/writeData, committed on clk negedge) between two writeback requesters: requester 0 (ALU result) and requester 1 (memory load result).
- Arbitrates round-robin using a valid/ready handshake and registers the winning write onto the port for exactly one cycle.
- Suppresses writes to register 0, honours a pipeline stall and counts committed writes.
- Sits between the writeback stage and the register file.

Parameters:
DATA_W, 32, data width of a register.
ADDR_W, 5, register address width (32 registers).
CNT_W, 16, width of the committed-write counter.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
stall  in  1  when high, no request is accepted this cycle.
req0_valid  in  1  requester 0 has a write pending.
req0_addr  in  ADDR_W  requester 0 destination register.
req0_data  in  DATA_W  requester 0 write data.
req0_ready  out  1  requester 0 accepted this cycle (valid && ready).
req1_valid  in  1  requester 1 has a write pending.
req1_addr  in  ADDR_W  requester 1 destination register.
req1_data  in  DATA_W  requester 1 write data.
req1_ready  out  1  requester 1 accepted this cycle.
writeEn  out  1  to register file write enable; registered.
writeAddr  out  ADDR_W  to register file write address; registered.
writeData  out  DATA_W  to register file write data; registered.
write_count  out  CNT_W  number of writes committed with writeEn=1; wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset=1 at posedge):
  - writeEn=0, writeAddr=0, writeData=0, write_count=0.
  - last_grant=1, so requester 0 wins the first contention.
  - req0_ready and req1_ready are forced 0 while reset is high.
- Ready generation (combinational from valid, stall, last_grant, reset):
  - stall=1 or reset=1: both readies 0.
  - Only one requester valid: that requester's ready=1.
  - Both valid: the requester not equal to last_grant gets ready=1; the other gets 0.
  - A ready never asserts without its own valid. At most one ready is high per cycle.
- Accept (posedge with valid && ready):
  - last_grant takes the accepted requester's index.
  - With no accept, last_grant holds.
- Output register (posedge after accept):
  - writeAddr and writeData load the accepted addr/data.
  - writeEn=1 only if the accepted addr != 0. Writes to register 0 are accepted (ready=1) but dropped: writeEn=0, write_count unchanged.
- No accept at a posedge: writeEn=0 next cycle; writeAddr and writeData hold their last values.
- Latency and throughput:
  - Latency is 1 cycle, accept edge to writeEn high.
  - Throughput is 1 write per cycle; back-to-back accepts produce back-to-back writeEn pulses.
  - Outputs are stable from posedge through the following negedge, where the register file commits.
- write_count increments at the same posedge that raises writeEn. It wraps 0xFFFF -> 0x0000.
- Requester holding rule: a requester keeps valid, addr and data stable until it sees ready. The block does not buffer beyond the output register.
- Stall asserted with writeEn already high: that write still completes; stall only blocks new accepts.
- Reset mid-operation: a pending output write is discarded (writeEn=0 next cycle); nothing is replayed.
- No state machine beyond last_grant and the output register. Two implicit states: IDLE (writeEn=0) and WRITE (writeEn=1), selected each cycle by whether an accept with nonzero addr occurred.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W and ADDR_W constants.
  - ZERO_REG = 0.
  - Requester index constants REQ_ALU = 0 and REQ_MEM = 1.
- One natural sub-module, rr_arbiter2: two-input round-robin grant logic holding last_grant, with inputs valid[1:0], stall and reset, and output grant[1:0].
- regfile_write_arbiter instantiates rr_arbiter2 and owns the output register and counter.

Test Plan:
- Reset held 2 cycles, then released with no valids -> writeEn=0, writeAddr=0, writeData=0, write_count=0, both readies 0 during reset.
- req0 only: addr=5, data=0xDEADBEEF for 1 cycle -> req0_ready=1 that cycle; next cycle writeEn=1, writeAddr=5, writeData=0xDEADBEEF; write_count=1.
- Both valid for 4 cycles (req0 addr=1/data=0x11, req1 addr=2/data=0x22) -> grants alternate 0,1,0,1; writeAddr sequence 1,2,1,2 on consecutive cycles; write_count=4.
- req1 valid with addr=0, data=0x55 -> req1_ready=1; next cycle writeEn=0; write_count unchanged.
- stall=1 with both valid for 3 cycles -> both readies 0 and writeEn=0 throughout; on stall release, req0 (or the non-last_grant requester) is granted first.
- write_count preloaded to 0xFFFF via 65535 writes (or forced), one more write -> write_count=0x0000; reset asserted while writeEn=1 -> next cycle writeEn=0 and write_count=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file writeback path.
package regfile_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 0;
    localparam int REQ_ALU  = 0;
    localparam int REQ_MEM  = 1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant with a one-bit history of the last accepted requester.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       stall,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last_grant;

    always_comb begin
        grant = 2'b00;
        if (!reset && !stall) begin
            if (valid[REQ_ALU] && valid[REQ_MEM]) begin
                // on contention the requester not served last goes first
                if (last_grant == 1'(REQ_ALU)) begin
                    grant[REQ_MEM] = 1'b1;
                end else begin
                    grant[REQ_ALU] = 1'b1;
                end
            end else begin
                grant = valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'(REQ_MEM);
        end else if (grant[REQ_MEM]) begin
            last_grant <= 1'(REQ_MEM);
        end else if (grant[REQ_ALU]) begin
            last_grant <= 1'(REQ_ALU);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU and load writeback paths,
// registering one accepted write per cycle and counting committed writes.
module regfile_write_arbiter #(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              writeEn,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeData,
    output logic [CNT_W-1:0]  write_count
);
    import regfile_pkg::ZERO_REG;
    import regfile_pkg::REQ_ALU;
    import regfile_pkg::REQ_MEM;

    logic [1:0]        grant;
    logic              accept;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              acc_commit;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[REQ_ALU];
    assign req1_ready = grant[REQ_MEM];
    assign accept     = |grant;
    assign acc_addr   = grant[REQ_MEM] ? req1_addr : req0_addr;
    assign acc_data   = grant[REQ_MEM] ? req1_data : req0_data;
    // register 0 is hardwired; such writes are handshaken but never committed
    assign acc_commit = accept && (acc_addr != ADDR_W'(ZERO_REG));

    always_ff @(posedge clk) begin
        if (reset) begin
            writeEn     <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
            write_count <= '0;
        end else begin
            writeEn <= acc_commit;
            if (accept) begin
                writeAddr <= acc_addr;
                writeData <= acc_data;
            end
            if (acc_commit) begin
                write_count <= write_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter with a queue scoreboard.
module tb_regfile_write_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset, stall;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, writeAddr;
    logic [DW-1:0] req0_data, req1_data, writeData;
    logic          writeEn;
    logic [CW-1:0] write_count;

    regfile_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .writeEn(writeEn), .writeAddr(writeAddr), .writeData(writeData), .write_count(write_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            mon_en   = 1'b0;
    int            served_last;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model decides who should win and what the port shows next.
    task automatic cycle(input logic rst, input logic st,
                         input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         output int win);
        reset = rst; stall = st;
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        #1;
        win = -1;
        if (!rst && !st) begin
            if (v0 && v1)  win = 1 - served_last;
            else if (v0)   win = 0;
            else if (v1)   win = 1;
        end
        check("req0_ready", req0_ready, win == 0);
        check("req1_ready", req1_ready, win == 1);
        m_en = 1'b0;
        if (rst) begin
            served_last = 1;
            m_count = '0;
            m_addr  = '0;
            m_data  = '0;
            exp_q.delete();
        end else if (win >= 0) begin
            served_last = win;
            m_addr = (win == 1) ? a1 : a0;
            m_data = (win == 1) ? d1 : d0;
            if (m_addr != 0) begin
                m_en = 1'b1;
                m_count = m_count + 1'b1;
                exp_q.push_back('{addr: m_addr, data: m_data});
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (writeEn === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write actual addr=0x%0h required=no write", writeAddr);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_addr", writeAddr, e.addr);
                        check("sb_data", writeData, e.data);
                    end
                end
                check("writeEn", writeEn, m_en);
                check("writeAddr", writeAddr, m_addr);
                check("writeData", writeData, m_data);
                check("write_count", write_count, m_count);
            end
        end
    end

    initial begin
        int            w;
        logic          p0v, p1v, st, rst;
        logic [AW-1:0] p0a, p1a;
        logic [DW-1:0] p0d, p1d;

        served_last = 1;
        // reset held two cycles, then idle
        cycle(1, 0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, w);
        mon_en = 1'b1;
        cycle(1, 0, 1, 5'd3, 32'h1, 1, 5'd4, 32'h2, w);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);
        // single ALU write
        cycle(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0, w);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);
        // contention from a fresh reset alternates 0,1,0,1
        cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 5'd1, 32'h11, 1, 5'd2, 32'h22, w);
            check("alt_grant", 2'(w), 2'(i % 2));
        end
        // write to register 0 is accepted but dropped
        cycle(0, 0, 0, 5'd0, 32'h0, 1, 5'd0, 32'h55, w);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);
        // stall blocks accepts; release grants the other-than-last requester
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88, w);
        cycle(0, 0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88, w);
        check("stall_release_grant", 2'(w), 2'd0);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);

        // randomized traffic honouring the hold-until-ready rule
        p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
        for (int i = 0; i < 600; i++) begin
            if (!p0v && $urandom_range(0, 2) != 0) begin
                p0v = 1;
                p0a = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                p0d = $urandom;
            end
            if (!p1v && $urandom_range(0, 2) != 0) begin
                p1v = 1;
                p1a = ($urandom_range(0, 3) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
                p1d = $urandom;
            end
            st  = ($urandom_range(0, 4) == 0);
            rst = ($urandom_range(0, 49) == 0);
            cycle(rst, st, p0v, p0a, p0d, p1v, p1a, p1d, w);
            if (w == 0) p0v = 0;
            if (w == 1) p1v = 0;
        end

        // fill the counter to 0xFFFF, wrap it, then reset while a write is on the port
        cycle(1, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);
        for (int i = 0; i < 65535; i++) begin
            cycle(0, 0, 1, AW'((i % 31) + 1), DW'(i), 0, 5'd0, 32'h0, w);
        end
        check("count_full", write_count, 16'hFFFF);
        cycle(0, 0, 0, 5'd0, 32'h0, 1, 5'd9, 32'hCAFE, w);
        check("count_wrap", write_count, 16'h0000);
        check("wrap_write_en", writeEn, 1'b1);
        cycle(1, 0, 1, 5'd3, 32'h3, 1, 5'd4, 32'h4, w);
        check("reset_drop_en", writeEn, 1'b0);
        check("reset_drop_count", write_count, 16'h0000);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);
        cycle(0, 0, 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, w);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
